// File: rtl/gpu_video_pkg.sv
// Shared video-timing definitions for the GPU output path.
// Provides SVGA 800x600 default timing, total-period derivation, the
// framebuffer address-width helper and the payload type carried by the
// sync alignment pipeline.
package gpu_video_pkg;

  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 40;
  localparam int unsigned DefHSync   = 128;
  localparam int unsigned DefHBp     = 88;

  localparam int unsigned DefVActive = 600;
  localparam int unsigned DefVFp     = 1;
  localparam int unsigned DefVSync   = 4;
  localparam int unsigned DefVBp     = 23;

  localparam int unsigned DefDownscale = 2;

  function automatic int unsigned calc_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned fb_addr_width(int unsigned res_x, int unsigned res_y);
    return $clog2(res_x * res_y);
  endfunction

  localparam int unsigned DefHTotal = calc_total(DefHActive, DefHFp, DefHSync, DefHBp);
  localparam int unsigned DefVTotal = calc_total(DefVActive, DefVFp, DefVSync, DefVBp);
  localparam int unsigned DefAw     = fb_addr_width(DefHActive / DefDownscale,
                                                    DefVActive / DefDownscale);

  // One raster position's worth of control bits, delayed alongside the read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_bits_t;

endpackage

// File: rtl/vga_timing_controller_if.sv
// Framebuffer read / palette return / VGA output bundle.
// master: timing controller (drives reads and VGA pins, receives palette colour).
// slave:  framebuffer/palette side and the display sink.
interface vga_timing_controller_if
  import gpu_video_pkg::*;
#(
  parameter int unsigned AW         = DefAw,
  parameter int unsigned RED_BITS   = 4,
  parameter int unsigned GREEN_BITS = 4,
  parameter int unsigned BLUE_BITS  = 4
);

  logic                  fb_rd_en;
  logic [AW-1:0]         fb_rd_addr;
  logic [RED_BITS-1:0]   pal_r;
  logic [GREEN_BITS-1:0] pal_g;
  logic [BLUE_BITS-1:0]  pal_b;
  logic                  vblank;
  logic                  frame_done;
  logic                  vga_hs;
  logic                  vga_vs;
  logic [RED_BITS-1:0]   vga_r;
  logic [GREEN_BITS-1:0] vga_g;
  logic [BLUE_BITS-1:0]  vga_b;

  modport master (
    output fb_rd_en, fb_rd_addr, vblank, frame_done, vga_hs, vga_vs, vga_r, vga_g, vga_b,
    input  pal_r, pal_g, pal_b
  );

  modport slave (
    input  fb_rd_en, fb_rd_addr, vblank, frame_done, vga_hs, vga_vs, vga_r, vga_g, vga_b,
    output pal_r, pal_g, pal_b
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to ResetValue.
// Ports: clk_i, rst_ni, d_i (Width) in; q_o (Width) = d_i delayed by Depth cycles.
module sync_delay_line #(
  parameter int unsigned      Width      = 1,
  parameter int unsigned      Depth      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= ResetValue;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing_controller.sv
// SVGA raster timing generator with downscaled framebuffer addressing.
// Ports: vga_clk (pixel clock), reset (async, active-low),
//        bus (master): fb_rd_en/fb_rd_addr out, pal_r/g/b in, vblank/frame_done out,
//        vga_hs/vga_vs/vga_r/g/b out, sync and colour aligned by SYNC_LATENCY+1.
module vga_timing_controller
  import gpu_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DefHActive,
  parameter int unsigned H_FP         = DefHFp,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_BP         = DefHBp,
  parameter int unsigned V_ACTIVE     = DefVActive,
  parameter int unsigned V_FP         = DefVFp,
  parameter int unsigned V_SYNC       = DefVSync,
  parameter int unsigned V_BP         = DefVBp,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned DOWNSCALE    = DefDownscale,
  parameter int unsigned SYNC_LATENCY = 3,
  parameter int unsigned RED_BITS     = 4,
  parameter int unsigned GREEN_BITS   = 4,
  parameter int unsigned BLUE_BITS    = 4
) (
  input logic                     vga_clk,
  input logic                     reset,
  vga_timing_controller_if.master bus
);

  localparam int unsigned H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned FB_RES_X = H_ACTIVE / DOWNSCALE;
  localparam int unsigned FB_RES_Y = V_ACTIVE / DOWNSCALE;
  localparam int unsigned AW       = fb_addr_width(FB_RES_X, FB_RES_Y);
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned Shift    = $clog2(DOWNSCALE);

  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActiveC   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HSyncStart = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HSyncEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActiveC   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VSyncStart = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VSyncEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VRowMask   = VW'(DOWNSCALE - 1);
  localparam logic [AW-1:0] RowStride  = AW'(FB_RES_X);

  localparam sync_bits_t SyncIdle = '{active: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic          h_last, v_last, last_subrow;
  logic          active;
  sync_bits_t    raw, dly;

  assign h_last      = (h_cnt_q == HLast);
  assign v_last      = (v_cnt_q == VLast);
  // Advance the framebuffer row only after its final replicated display line.
  assign last_subrow = ((v_cnt_q & VRowMask) == VRowMask) && (v_cnt_q < VActiveC);

  always_comb begin
    h_cnt_d     = h_cnt_q + 1'b1;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    if (h_last) begin
      h_cnt_d = '0;
      if (v_last) begin
        v_cnt_d     = '0;
        line_base_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
        if (last_subrow) line_base_d = line_base_q + RowStride;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
    end
  end

  assign active = (h_cnt_q < HActiveC) && (v_cnt_q < VActiveC);

  always_comb begin
    raw.active = active;
    raw.hs     = ((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd)) ? HS_POL : ~HS_POL;
    raw.vs     = ((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd)) ? VS_POL : ~VS_POL;
  end

  // Counters sit at (0,0) during reset, so the raster is presented as soon as it lifts.
  assign bus.fb_rd_en   = active & reset;
  assign bus.fb_rd_addr = line_base_q + AW'(h_cnt_q >> Shift);
  assign bus.vblank     = (v_cnt_q >= VActiveC);
  assign bus.frame_done = (h_cnt_q == '0) && (v_cnt_q == VActiveC);

  sync_delay_line #(
    .Width      ($bits(sync_bits_t)),
    .Depth      (SYNC_LATENCY),
    .ResetValue (SyncIdle)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset),
    .d_i    (raw),
    .q_o    (dly)
  );

  logic                  vga_hs_q, vga_vs_q;
  logic [RED_BITS-1:0]   vga_r_q;
  logic [GREEN_BITS-1:0] vga_g_q;
  logic [BLUE_BITS-1:0]  vga_b_q;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      vga_hs_q <= ~HS_POL;
      vga_vs_q <= ~VS_POL;
      vga_r_q  <= '0;
      vga_g_q  <= '0;
      vga_b_q  <= '0;
    end else begin
      vga_hs_q <= dly.hs;
      vga_vs_q <= dly.vs;
      vga_r_q  <= dly.active ? bus.pal_r : '0;
      vga_g_q  <= dly.active ? bus.pal_g : '0;
      vga_b_q  <= dly.active ? bus.pal_b : '0;
    end
  end

  assign bus.vga_hs = vga_hs_q;
  assign bus.vga_vs = vga_vs_q;
  assign bus.vga_r  = vga_r_q;
  assign bus.vga_g  = vga_g_q;
  assign bus.vga_b  = vga_b_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a shrunken raster (16x10 totals,
// 8x6 active) so whole frames fit in a short run. Instance a: DOWNSCALE=2, latency 3.
// Instance b: DOWNSCALE=1, latency 1.
module tb_vga_timing_controller;

  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3, HT = 16;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 1, VT = 10;
  localparam int FRAME = HT * VT;
  localparam int AW_A = 4, AW_B = 6;
  localparam int LAT_A = 3, LAT_B = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  vga_timing_controller_if #(.AW(AW_A)) bus_a ();
  vga_timing_controller_if #(.AW(AW_B)) bus_b ();

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .DOWNSCALE(2), .SYNC_LATENCY(LAT_A)
  ) dut_a (
    .vga_clk (clk),
    .reset   (rst_n),
    .bus     (bus_a)
  );

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .DOWNSCALE(1), .SYNC_LATENCY(LAT_B)
  ) dut_b (
    .vga_clk (clk),
    .reset   (rst_n),
    .bus     (bus_b)
  );

  // Palette models: colour for a read appears LAT cycles later.
  logic [AW_A-1:0] pipe_a [LAT_A];
  logic [AW_B-1:0] pipe_b;

  always @(posedge clk) begin
    pipe_a[0] <= bus_a.fb_rd_addr;
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= bus_b.fb_rd_addr;
  end

  assign bus_a.pal_r = pipe_a[LAT_A-1][3:0];
  assign bus_a.pal_g = ~pipe_a[LAT_A-1][3:0];
  assign bus_a.pal_b = 4'hF;
  assign bus_b.pal_r = pipe_b[3:0];
  assign bus_b.pal_g = ~pipe_b[3:0];
  assign bus_b.pal_b = 4'hF;

  function automatic bit m_act(int c);
    return ((c % HT) < HA) && (((c / HT) % VT) < VA);
  endfunction

  function automatic int m_addr(int c, int ds);
    int h = c % HT;
    int v = (c / HT) % VT;
    return (v / ds) * (HA / ds) + h / ds;
  endfunction

  function automatic bit m_hs(int c);
    int h = c % HT;
    return (h >= HA + HFP) && (h < HA + HFP + HSY);
  endfunction

  function automatic bit m_vs(int c);
    int v = (c / HT) % VT;
    return (v >= VA + VFP) && (v < VA + VFP + VSY);
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_inst(input string n, input int c, input int ds, input int lat,
                            input logic [31:0] en, input logic [31:0] addr,
                            input logic [31:0] vb, input logic [31:0] fd,
                            input logic [31:0] hs, input logic [31:0] vs,
                            input logic [31:0] r, input logic [31:0] g,
                            input logic [31:0] b);
    int  d  = c - lat - 1;
    int  h  = c % HT;
    int  v  = (c / HT) % VT;
    bit  da = (d >= 0) && m_act(d);
    int  a  = (d >= 0) ? (m_addr(d, ds) & 15) : 0;
    chk({n, ".fb_rd_en"}, c, en, 32'(m_act(c)));
    if (m_act(c)) chk({n, ".fb_rd_addr"}, c, addr, 32'(m_addr(c, ds)));
    chk({n, ".vblank"}, c, vb, 32'(v >= VA));
    chk({n, ".frame_done"}, c, fd, 32'((h == 0) && (v == VA)));
    chk({n, ".vga_hs"}, c, hs, 32'((d >= 0) && m_hs(d)));
    chk({n, ".vga_vs"}, c, vs, 32'((d >= 0) && m_vs(d)));
    chk({n, ".vga_r"}, c, r, da ? 32'(a) : 32'd0);
    chk({n, ".vga_g"}, c, g, da ? 32'(15 - a) : 32'd0);
    chk({n, ".vga_b"}, c, b, da ? 32'd15 : 32'd0);
  endtask

  task automatic check_cycle(input int c);
    check_inst("a", c, 2, LAT_A, 32'(bus_a.fb_rd_en), 32'(bus_a.fb_rd_addr),
               32'(bus_a.vblank), 32'(bus_a.frame_done), 32'(bus_a.vga_hs),
               32'(bus_a.vga_vs), 32'(bus_a.vga_r), 32'(bus_a.vga_g), 32'(bus_a.vga_b));
    check_inst("b", c, 1, LAT_B, 32'(bus_b.fb_rd_en), 32'(bus_b.fb_rd_addr),
               32'(bus_b.vblank), 32'(bus_b.frame_done), 32'(bus_b.vga_hs),
               32'(bus_b.vga_vs), 32'(bus_b.vga_r), 32'(bus_b.vga_g), 32'(bus_b.vga_b));
  endtask

  task automatic check_reset(input int c);
    chk("rst.a.vga_hs", c, 32'(bus_a.vga_hs), 32'd0);
    chk("rst.a.vga_vs", c, 32'(bus_a.vga_vs), 32'd0);
    chk("rst.a.vga_rgb", c, {20'd0, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b}, 32'd0);
    chk("rst.a.fb_rd_en", c, 32'(bus_a.fb_rd_en), 32'd0);
    chk("rst.a.fb_rd_addr", c, 32'(bus_a.fb_rd_addr), 32'd0);
    chk("rst.a.vblank_fd", c, {30'd0, bus_a.vblank, bus_a.frame_done}, 32'd0);
    chk("rst.b.sync", c, {30'd0, bus_b.vga_hs, bus_b.vga_vs}, 32'd0);
    chk("rst.b.vga_rgb", c, {20'd0, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b}, 32'd0);
    chk("rst.b.fb_rd_en", c, 32'(bus_b.fb_rd_en), 32'd0);
  endtask

  // Statistics gathered from instance a during a run.
  int fd_count, fd_first, fd_second, vblank_f0, vs_f0, hs_rise0, hs_rise1, hs_fall0;

  task automatic run(input int ncycles);
    logic prev_hs = 1'b0;
    fd_count = 0; fd_first = -1; fd_second = -1; vblank_f0 = 0; vs_f0 = 0;
    hs_rise0 = -1; hs_rise1 = -1; hs_fall0 = -1;
    for (int c = 0; c < ncycles; c++) begin
      check_cycle(c);
      if (bus_a.frame_done === 1'b1) begin
        if (fd_count == 0) fd_first = c;
        else if (fd_count == 1) fd_second = c;
        fd_count++;
      end
      if (c < FRAME && bus_a.vblank === 1'b1) vblank_f0++;
      if (c < FRAME && bus_a.vga_vs === 1'b1) vs_f0++;
      if (bus_a.vga_hs === 1'b1 && !prev_hs) begin
        if (hs_rise0 < 0) hs_rise0 = c;
        else if (hs_rise1 < 0) hs_rise1 = c;
      end
      if (bus_a.vga_hs === 1'b0 && prev_hs && hs_fall0 < 0) hs_fall0 = c;
      prev_hs = bus_a.vga_hs;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(-1);

    // Two full frames plus a little; frame_done at 6*16 and 6*16+160.
    rst_n = 1'b1;
    #1;
    run(2 * FRAME + 8);
    chk("frame_done.count", 0, 32'(fd_count), 32'd2);
    chk("frame_done.first", 0, 32'(fd_first), 32'd96);
    chk("frame_done.second", 0, 32'(fd_second), 32'd256);
    chk("vblank.cycles_per_frame", 0, 32'(vblank_f0), 32'd64);
    chk("vga_vs.cycles_per_frame", 0, 32'(vs_f0), 32'd32);
    chk("vga_hs.first_rise", 0, 32'(hs_rise0), 32'd14);
    chk("vga_hs.period", 0, 32'(hs_rise1 - hs_rise0), 32'd16);
    chk("vga_hs.width", 0, 32'(hs_fall0 - hs_rise0), 32'd3);

    // Reset mid-frame (line 3, pixel 5 of a fresh restart), then restart cleanly.
    rst_n = 1'b0;
    #1;
    check_reset(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset(i + 1);
    end
    rst_n = 1'b1;
    #1;
    run(3 * HT + 5);
    rst_n = 1'b0;
    #1;
    check_reset(100);
    repeat (5) @(negedge clk);
    check_reset(105);
    rst_n = 1'b1;
    #1;
    run(FRAME + 8);
    chk("restart.frame_done.count", 0, 32'(fd_count), 32'd1);
    chk("restart.frame_done.first", 0, 32'(fd_first), 32'd96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Downstream video-out stage of the GPU, in the `vga_clk` domain. Generates SVGA 800x600 raster timing, issues framebuffer read addresses at the downscaled 400x300 resolution, and receives the palette-resolved colour. It delays sync and blank by the fixed read latency so that `vga_hs`, `vga_vs` and `vga_r/g/b` leave the chip aligned.

## Interface
- `H_ACTIVE` 800, `H_FP` 40, `H_SYNC` 128, `H_BP` 88: horizontal timing in pixel clocks.
- `V_ACTIVE` 600, `V_FP` 1, `V_SYNC` 4, `V_BP` 23: vertical timing in lines.
- `HS_POL` 1, `VS_POL` 1: active level of the sync pulses.
- `DOWNSCALE` 2: pixel replication factor; must be a power of two.
- `SYNC_LATENCY` 3: cycles from `fb_rd_en` to valid `pal_*` input; must be ≥1.
- `RED_BITS` 4, `GREEN_BITS` 4, `BLUE_BITS` 4: colour channel widths.
- Derived: `FB_RES_X`=H_ACTIVE/DOWNSCALE; `FB_RES_Y`=V_ACTIVE/DOWNSCALE; `AW`=$clog2(FB_RES_X*FB_RES_Y) (17 at defaults).

Ports:
- `vga_clk` in 1: pixel clock (40 MHz at defaults).
- `reset` in 1: **asynchronous, active-low** reset. This block has one clock only.
- `fb_rd_en` out 1: framebuffer read strobe; high during the active area only.
- `fb_rd_addr` out AW: framebuffer byte address of the current pixel.
- `pal_r`/`pal_g`/`pal_b` in RED_BITS/GREEN_BITS/BLUE_BITS: colour for the read issued SYNC_LATENCY cycles earlier.
- `vblank` out 1: high while v_cnt ≥ V_ACTIVE (undelayed).
- `frame_done` out 1: one-cycle pulse at h_cnt=0, v_cnt=V_ACTIVE.
- `vga_hs`, `vga_vs` out 1: sync outputs, delayed SYNC_LATENCY+1.
- `vga_r`/`vga_g`/`vga_b` out channel widths: registered colour; zero when blanked.

## Operation
- **Counters.**
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (1056).
  - `v_cnt` counts 0..V_TOTAL-1 (628). It increments when `h_cnt` wraps to 0, and both counters wrap together at (H_TOTAL-1, V_TOTAL-1).
- **Active area.** `active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- **Sync pulses.**
  - `hs_raw` = HS_POL while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise it is the inverse.
  - `vs_raw` is formed the same way from the V parameters.
- **Address generation.** No multiplier is used.
  - `line_base` (AW bits) holds the framebuffer row start address.
  - `fb_rd_addr` = line_base + (h_cnt >> log2(DOWNSCALE)), combinational from registers.
  - At h_cnt=H_TOTAL-1:
    - if v_cnt = V_TOTAL-1, `line_base` is set to 0;
    - otherwise, if (v_cnt mod DOWNSCALE) = DOWNSCALE-1 and v_cnt < V_ACTIVE, `line_base` is incremented by FB_RES_X;
    - in all other cases it holds.
  - Each framebuffer row is read DOWNSCALE times and each address is repeated DOWNSCALE times.
  - Addresses run 0..FB_RES_X*FB_RES_Y-1 and never overflow AW.
  - `fb_rd_addr` is don't-care when `fb_rd_en`=0.
- **Delay line.** `{active, hs_raw, vs_raw}` passes through a SYNC_LATENCY-stage shift register.
- **Output register.** The final stage registers all outputs:
  - `vga_hs`/`vga_vs` take the delayed sync values.
  - `vga_r/g/b` take `pal_*` when the delayed active bit is set; otherwise they take 0.

## Timing
- **Reset values** (while `reset`=0, applied asynchronously):
  - `h_cnt`=`v_cnt`=`line_base`=0, so `fb_rd_addr`=0.
  - All delay stages hold inactive sync and active=0.
  - `vga_hs`=~HS_POL, `vga_vs`=~VS_POL, `vga_r/g/b`=0, `vblank`=0, `frame_done`=0.
  - `fb_rd_en`=0 while `reset` is asserted.
- **After reset release:**
  - The first rising edge advances `h_cnt` to 1.
  - The raster starts at (0,0) combinationally on release, so `fb_rd_en`=1 and address 0 are presented before that first edge.
- **Latency.** A read issued at edge t has its colour on `vga_r/g/b` after edge t+SYNC_LATENCY+1. `vga_hs`/`vga_vs` for the same raster position appear on that same edge.
- **Reset mid-frame.** All state aborts immediately and the raster restarts at (0,0). No partial line is completed and no `frame_done` is emitted.
- **Simultaneous events.** At (H_TOTAL-1, V_TOTAL-1), the `h_cnt` wrap, the `v_cnt` wrap and the `line_base` clear occur on the same edge.
- **Frame rate.** `frame_done` pulses exactly once per H_TOTAL*V_TOTAL cycles (663168).

## Structure
- **Shared package `gpu_video_pkg`:**
  - default SVGA timing constants;
  - H_TOTAL/V_TOTAL derivations;
  - an address-width helper returning $clog2(FB_RES_X*FB_RES_Y).
- **Sub-module `sync_delay_line`:** parameterised width and depth, async active-low reset to a parameterised reset value. It is reused for the alignment pipeline.
- Counters and address generation stay in the top module.

## Test plan
- **Reset:** hold `reset`=0 for 5 cycles mid-frame. Required: `vga_hs`=0, `vga_vs`=0, `vga_r/g/b`=0, `fb_rd_en`=0. After release, the address sequence restarts at 0 and `frame_done` pulses after 600*1056 = 633600 cycles.
- **Line timing:** count cycles per line. Required: `vga_hs` high for exactly 128 cycles, 1056-cycle period, rising SYNC_LATENCY+1 cycles after h_cnt=840. `vga_vs` is high for 4 lines starting at line 601.
- **Address sequence:**
  - line 0 gives 0,0,1,1,…,399,399;
  - line 1 repeats the line-0 sequence;
  - line 2 starts at 400;
  - line 599 ends at 119999;
  - `fb_rd_en` is low for h_cnt ≥ 800 and for lines ≥ 600.
- **Latency alignment:** a bench model returns `pal_r`=addr[3:0] three cycles after each read. Required: the `vga_r` sequence equals the model, shifted by exactly 4 cycles from `fb_rd_en`. `vga_r/g/b` is 0 on every blanked cycle even when `pal_*`=4'hF.
- **Frame wrap:** run 2 full frames. Required: `frame_done` pulses at cycles 633600 and 1296768; `vblank` is high for 28*1056 cycles per frame; the second frame's addresses restart at 0.
- **Parameter variant:** with DOWNSCALE=1 and SYNC_LATENCY=1, addresses step by 1 per pixel and run 0..479999 with AW=19. RGB appears 2 cycles after the read.
